// File: rtl/unidad_control.sv
// Multicycle control unit for a ld/sd/beq datapath: sequences fetch, decode,
// execute, memory and writeback, with a memory-wait timeout and sticky fault state.
module unidad_control #(
    parameter int Bits    = 64,
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        alu_src,
    output logic [1:0]  alu_op,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        error,
    output logic [31:0] retired
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int unused_width = Bits;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, ERROR} state_t;
    typedef enum logic [1:0] {CLS_NONE, CLS_LD, CLS_SD, CLS_BEQ} cls_t;

    state_t         state_reg;
    cls_t           cls_reg;
    cls_t           cls_next;
    logic [CW-1:0]  wait_reg;
    logic [31:0]    retired_reg;
    logic           timeout_hit;
    logic           unused_instr;

    assign unused_instr = ^instr[31:7];

    always_comb begin
        cls_next = CLS_NONE;
        case (instr[6:0])
            7'b0000011: cls_next = CLS_LD;
            7'b0100011: cls_next = CLS_SD;
            7'b1100011: cls_next = CLS_BEQ;
            default:    cls_next = CLS_NONE;
        endcase
    end

    // This is the TIMEOUT-th unacknowledged request cycle; an ack in it still wins.
    assign timeout_hit = (wait_reg == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= FETCH;
            cls_reg     <= CLS_NONE;
            wait_reg    <= '0;
            retired_reg <= '0;
        end else begin
            case (state_reg)
                FETCH: begin
                    if (mem_ack) begin
                        state_reg <= DECODE;
                        wait_reg  <= '0;
                    end else if (timeout_hit) begin
                        state_reg <= ERROR;
                    end else begin
                        wait_reg <= wait_reg + 1'b1;
                    end
                end
                DECODE: begin
                    cls_reg   <= cls_next;
                    state_reg <= (cls_next == CLS_NONE) ? ERROR : EXEC;
                end
                EXEC: begin
                    wait_reg <= '0;
                    if (cls_reg == CLS_BEQ) begin
                        retired_reg <= retired_reg + 1'b1;
                        state_reg   <= FETCH;
                    end else begin
                        state_reg <= MEM;
                    end
                end
                MEM: begin
                    if (mem_ack) begin
                        wait_reg <= '0;
                        if (cls_reg == CLS_SD) begin
                            retired_reg <= retired_reg + 1'b1;
                            state_reg   <= FETCH;
                        end else begin
                            state_reg <= WB;
                        end
                    end else if (timeout_hit) begin
                        state_reg <= ERROR;
                    end else begin
                        wait_reg <= wait_reg + 1'b1;
                    end
                end
                WB: begin
                    retired_reg <= retired_reg + 1'b1;
                    wait_reg    <= '0;
                    state_reg   <= FETCH;
                end
                ERROR:   state_reg <= ERROR;
                default: state_reg <= ERROR;
            endcase
        end
    end

    // Outputs idle while reset is held so no request escapes mid-reset.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        alu_src    = 1'b0;
        alu_op     = 2'b11;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        error      = 1'b0;
        if (!reset) begin
            case (state_reg)
                FETCH: begin
                    mem_req  = 1'b1;
                    ir_write = mem_ack;
                    pc_write = mem_ack;
                end
                EXEC: begin
                    if (cls_reg == CLS_BEQ) begin
                        alu_op   = 2'b01;
                        pc_src   = 1'b1;
                        pc_write = zero;
                    end else begin
                        alu_src = 1'b1;
                        alu_op  = 2'b00;
                    end
                end
                MEM: begin
                    mem_req = 1'b1;
                    mem_we  = (cls_reg == CLS_SD);
                end
                WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                ERROR:   error = 1'b1;
                default: ;
            endcase
        end
    end

    assign retired = retired_reg;

endmodule

// File: tb/tb_unidad_control.sv
// Self-checking bench for unidad_control: directed scenarios followed by random
// instruction streams compared against an instruction-level timing model.
module tb_unidad_control;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        zero;
    logic        mem_ack;
    logic        mem_req, mem_we, ir_write, pc_write, pc_src, alu_src;
    logic [1:0]  alu_op;
    logic        reg_write, mem_to_reg, error;
    logic [31:0] retired;

    int checks = 0;
    int errors = 0;
    int exp_ret = 0;

    unidad_control #(.Bits(64), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .instr(instr), .zero(zero), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .alu_src(alu_src), .alu_op(alu_op), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .error(error), .retired(retired)
    );

    always #5 clk = ~clk;

    wire [10:0] ctl_obs = {mem_req, mem_we, ir_write, pc_write, pc_src, alu_src,
                           alu_op, reg_write, mem_to_reg, error};

    function automatic logic [10:0] ctl(input logic req, input logic we, input logic irw,
                                        input logic pcw, input logic pcs, input logic asrc,
                                        input logic [1:0] aop, input logic rw,
                                        input logic m2r, input logic err);
        return {req, we, irw, pcw, pcs, asrc, aop, rw, m2r, err};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs already driven, outputs sampled on the falling edge.
    task automatic check_cycle(input string tag, input logic [10:0] e);
        @(negedge clk);
        chk({tag, " ctl"}, 32'(ctl_obs), 32'(e));
        chk({tag, " retired"}, retired, exp_ret);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        mem_ack = 1'($urandom);
        @(negedge clk);
        chk("reset mem_req", 32'(mem_req), 32'd0);
        @(posedge clk);
        #1;
        exp_ret = 0;
        @(negedge clk);
        chk("reset hold mem_req", 32'(mem_req), 32'd0);
        chk("reset retired", retired, 32'd0);
        chk("reset error", 32'(error), 32'd0);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        mem_ack = 1'b0;
    endtask

    task automatic error_hold(input int hold);
        for (int h = 0; h < hold; h++) begin
            mem_ack = 1'($urandom);
            zero    = 1'($urandom);
            instr   = $urandom;
            check_cycle("error", ctl(0, 0, 0, 0, 0, 0, 2'b11, 0, 0, 1));
        end
        do_reset();
    endtask

    // Instruction-level model: fwait/mwait are the number of unacknowledged
    // request cycles before ack; TO or more means the ack never comes.
    task automatic run_instr(input logic [31:0] iw, input int fwait, input int mwait,
                             input logic z, input int hold, input int abort_at);
        logic is_ld, is_sd, is_beq;
        is_ld  = (iw[6:0] == 7'b0000011);
        is_sd  = (iw[6:0] == 7'b0100011);
        is_beq = (iw[6:0] == 7'b1100011);
        instr  = iw;
        zero   = 1'($urandom);
        for (int k = 0; k < TO; k++) begin
            mem_ack = (k == fwait);
            check_cycle("fetch", ctl(1, 0, mem_ack, mem_ack, 0, 0, 2'b11, 0, 0, 0));
            if (k == fwait) break;
        end
        if (fwait >= TO) begin
            error_hold(hold);
            return;
        end
        mem_ack = 1'($urandom);
        check_cycle("decode", ctl(0, 0, 0, 0, 0, 0, 2'b11, 0, 0, 0));
        instr = $urandom;
        if (!(is_ld || is_sd || is_beq)) begin
            error_hold(hold);
            return;
        end
        mem_ack = 1'($urandom);
        if (is_beq) begin
            zero = z;
            check_cycle("exec_beq", ctl(0, 0, 0, z, 1, 0, 2'b01, 0, 0, 0));
            exp_ret++;
            return;
        end
        check_cycle("exec_mem", ctl(0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0));
        for (int k = 0; k < TO; k++) begin
            if (k == abort_at) begin
                do_reset();
                return;
            end
            mem_ack = (k == mwait);
            check_cycle("mem", ctl(1, is_sd, 0, 0, 0, 0, 2'b11, 0, 0, 0));
            if (k == mwait) break;
        end
        if (mwait >= TO) begin
            error_hold(hold);
            return;
        end
        if (is_sd) begin
            exp_ret++;
            return;
        end
        mem_ack = 1'($urandom);
        check_cycle("wb", ctl(0, 0, 0, 0, 0, 0, 2'b11, 1, 1, 0));
        exp_ret++;
    endtask

    function automatic int pick_wait();
        int r;
        r = int'($urandom_range(0, 19));
        if (r == 0) return TO - 1;
        if (r == 1) return TO;
        return int'($urandom_range(0, 3));
    endfunction

    initial begin
        logic [31:0] iw;
        int r;
        reset   = 1'b1;
        instr   = 32'd0;
        zero    = 1'b0;
        mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("init mem_req", 32'(mem_req), 32'd0);
        chk("init retired", retired, 32'd0);
        chk("init error", 32'(error), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_instr(32'h00003083, 0, 0, 1'b0, 1, -1);
        run_instr(32'h00000063, 0, 0, 1'b1, 1, -1);
        run_instr(32'h00000063, 0, 0, 1'b0, 1, -1);
        run_instr(32'h00113023, 0, 3, 1'b0, 1, -1);
        run_instr(32'h00000033, 0, 0, 1'b0, 20, -1);
        run_instr(32'h00003083, TO, 0, 1'b0, 3, -1);
        run_instr(32'h00003083, TO - 1, TO - 1, 1'b0, 1, -1);
        run_instr(32'h00113023, 0, TO, 1'b0, 2, -1);
        run_instr(32'h00113023, 1, 5, 1'b0, 1, 2);
        run_instr(32'h00003083, 0, 0, 1'b1, 1, -1);

        for (int n = 0; n < 150; n++) begin
            iw = $urandom;
            r  = int'($urandom_range(0, 9));
            if (r < 3)      iw[6:0] = 7'b0000011;
            else if (r < 6) iw[6:0] = 7'b0100011;
            else if (r < 9) iw[6:0] = 7'b1100011;
            else begin
                while (iw[6:0] == 7'b0000011 || iw[6:0] == 7'b0100011 ||
                       iw[6:0] == 7'b1100011)
                    iw = $urandom;
            end
            run_instr(iw, pick_wait(), pick_wait(), 1'($urandom),
                      int'($urandom_range(1, 4)),
                      ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 3)) : -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/unidad_control.md
UNIDAD_CONTROL -- requirements
Module: unidad_control

Interface
REQ-001 Parameter: Bits, 64, datapath width; affects nothing in this block beyond documentation consistency with the immediate generator.
REQ-002 Parameter: TIMEOUT, 16, max cycles a memory request may wait for mem_ack before error.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: instr  input  32  instruction register contents; opcode = instr[6:0].
REQ-006 Port: zero  input  1  ALU equality flag, valid in EXEC.
REQ-007 Port: mem_ack  input  1  memory completion strobe for the current request.
REQ-008 Port: mem_req  output  1  memory request, held until mem_ack or timeout.
REQ-009 Port: mem_we  output  1  1 = store write, 0 = read.
REQ-010 Port: ir_write  output  1  latch fetched word into instruction register.
REQ-011 Port: pc_write  output  1  update PC.
REQ-012 Port: pc_src  output  1  0 = PC+4, 1 = branch target.
REQ-013 Port: alu_src  output  1  1 = immediate operand, 0 = register operand.
REQ-014 Port: alu_op  output  2  00 = add (address), 01 = subtract (compare), 11 = idle.
REQ-015 Port: reg_write  output  1  register file write enable.
REQ-016 Port: mem_to_reg  output  1  writeback source is memory data.
REQ-017 Port: error  output  1  sticky fault flag (illegal opcode or memory timeout).
REQ-018 Port: retired  output  32  count of completed instructions.

Function
REQ-019 FSM states SHALL be FETCH, DECODE, EXEC, MEM, WB, ERROR.
REQ-020 FETCH: mem_req=1, mem_we=0; in a cycle with mem_ack=1, ir_write=1, pc_write=1, pc_src=0, next DECODE; else stay.
REQ-021 DECODE (1 cycle): opcode 0000011 (ld), 0100011 (sd), 1100011 (beq) -> EXEC; any other opcode -> ERROR.
REQ-022 EXEC ld/sd: alu_src=1, alu_op=00, next MEM.
REQ-023 EXEC beq: alu_src=0, alu_op=01; pc_src=1 and pc_write=zero in the same cycle; retired increments; next FETCH.
REQ-024 MEM: mem_req=1, mem_we=1 for sd and 0 for ld; on mem_ack, sd -> FETCH with retired increment, ld -> WB.
REQ-025 WB: reg_write=1, mem_to_reg=1, retired increments, next FETCH.
REQ-026 Outputs not listed as asserted in a state SHALL be 0, except alu_op, which SHALL be 11.
REQ-027 Opcode class SHALL be captured in DECODE into a register; instr changes after DECODE SHALL NOT alter sequencing.
REQ-028 Wait counter SHALL clear on entry to FETCH/MEM and count each cycle mem_req=1 without mem_ack; reaching TIMEOUT without ack -> ERROR.
REQ-029 mem_ack in the same cycle the counter reaches TIMEOUT SHALL count as success (ack wins).
REQ-030 mem_ack outside FETCH/MEM SHALL be ignored.
REQ-031 ERROR: all enables 0, mem_req=0, alu_op=11, error=1; exit only by reset.
REQ-032 retired SHALL wrap from 0xFFFFFFFF to 0; it increments at most once per cycle.
REQ-033 Latency with immediate ack: beq 3 cycles, sd 4, ld 5; each wait cycle adds one.

Reset
REQ-034 reset=1 at a clock edge SHALL force FETCH, clear error, retired, wait counter and captured opcode, regardless of the current state, including mid-request.
REQ-035 During and in the cycle after reset: mem_req=0 while reset is high; the first request begins in the first cycle after reset deasserts.

Verification
REQ-036 ld (0x00003083), mem_ack held 1 -> states FETCH, DECODE, EXEC, MEM, WB; reg_write=1 in cycle 5; retired=1.
REQ-037 beq with zero=1, then beq with zero=0 -> first gives pc_write=1, pc_src=1 in EXEC; second gives pc_write=0; retired=2.
REQ-038 sd (0x00113023), MEM ack delayed 3 cycles -> mem_we=1 and mem_req held 4 cycles; FETCH entered on cycle after ack; total 7 cycles.
REQ-039 opcode 0110011 -> ERROR after DECODE; error=1 persists over 20 cycles; reset -> error=0, FETCH.
REQ-040 mem_ack never asserted in FETCH, TIMEOUT=16 -> ERROR after 16 request cycles; ack arriving exactly at cycle 16 -> DECODE instead.
REQ-041 reset asserted in MEM with mem_req=1 -> next cycle FETCH, mem_req=0 while reset high, retired=0.
